// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-side signal bundle for the two-port memory arbiter.
// Latency: none, wiring only.
// Backpressure: requests are level-held until the one-cycle ack pulse.
interface mem_port_arbiter_if #(
  parameter int ADDR_WIDTH = 20,
  parameter int DATA_WIDTH = 8
);
  // requester side
  logic                  req0;
  logic                  req1;
  logic                  we0;
  logic                  we1;
  logic [ADDR_WIDTH-1:0] addr0;
  logic [ADDR_WIDTH-1:0] addr1;
  logic [DATA_WIDTH-1:0] wdata0;
  logic [DATA_WIDTH-1:0] wdata1;
  logic                  ack0;
  logic                  ack1;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            gnt;
  // memory module strobes and address (data bus is a separate inout)
  logic                  mem_cs;
  logic                  mem_rd;
  logic                  mem_wr;
  logic [ADDR_WIDTH-1:0] mem_address;

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
    input  ack0, ack1, rdata, gnt, mem_cs, mem_rd, mem_wr, mem_address
  );

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
    output ack0, ack1, rdata, gnt, mem_cs, mem_rd, mem_wr, mem_address
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-port arbiter sequencing one memory module through strobe/access/recovery.
// Latency: request sampled in IDLE -> ack and read data 3 cycles later.
// Backpressure: losing port holds its request; it is served back-to-back from DONE.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH = 20,
  parameter int DATA_WIDTH = 8,
  parameter int FIXED_PRIO = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  mem_port_arbiter_if.slave     bus,
  inout  wire [DATA_WIDTH-1:0]  mem_data
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ISSUE  = 2'd1,
    S_ACCESS = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t                state;
  state_t                state_nxt;

  // arbitration result for the current cycle
  logic                  win_vld;
  logic                  win_port;
  logic                  grant;
  logic                  sel_we;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;

  // transaction latched at grant
  logic                  owner;
  logic                  last;
  logic                  lat_we;
  logic [DATA_WIDTH-1:0] lat_wdata;

  // registered memory-side and requester-side outputs
  logic                  mem_cs_q;
  logic                  mem_rd_q;
  logic                  mem_wr_q;
  logic                  data_oe;
  logic [ADDR_WIDTH-1:0] mem_address_q;
  logic [1:0]            gnt_q;
  logic [1:0]            ack_q;
  logic [DATA_WIDTH-1:0] rdata_q;

  // next-value terms for the output registers
  logic                  cs_nxt;
  logic                  rd_nxt;
  logic                  wr_nxt;
  logic                  oe_nxt;
  logic [1:0]            gnt_nxt;
  logic [1:0]            ack_nxt;

  // State register; reset drops any in-flight transaction without an ack.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next state plus arbitration; in DONE the port just served is excluded.
  always_comb begin
    logic cand0;
    logic cand1;
    cand0 = bus.req0;
    cand1 = bus.req1;
    if (state == S_DONE) begin
      if (owner) cand1 = 1'b0;
      else       cand0 = 1'b0;
    end
    win_vld = cand0 | cand1;
    if (cand0 && cand1) win_port = (FIXED_PRIO != 0) ? 1'b0 : ~last;
    else                win_port = cand1;

    state_nxt = state;
    case (state)
      S_IDLE:   if (win_vld) state_nxt = S_ISSUE;
      S_ISSUE:  state_nxt = S_ACCESS;
      S_ACCESS: state_nxt = S_DONE;
      S_DONE:   state_nxt = win_vld ? S_ISSUE : S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Output decode: compute the register inputs from the state being entered.
  always_comb begin
    grant     = (state_nxt == S_ISSUE);
    sel_we    = win_port ? bus.we1    : bus.we0;
    sel_addr  = win_port ? bus.addr1  : bus.addr0;
    sel_wdata = win_port ? bus.wdata1 : bus.wdata0;

    cs_nxt = grant;
    rd_nxt = !(grant && !sel_we);
    wr_nxt = !(grant && sel_we);
    // write data is on the bus through ISSUE and ACCESS, never while the memory drives
    oe_nxt = (grant && sel_we) || ((state_nxt == S_ACCESS) && lat_we);

    gnt_nxt = gnt_q;
    if (state_nxt == S_IDLE) gnt_nxt = 2'b00;
    else if (grant)          gnt_nxt = win_port ? 2'b10 : 2'b01;

    ack_nxt = 2'b00;
    if (state_nxt == S_DONE) ack_nxt = owner ? 2'b10 : 2'b01;
  end

  // Output and datapath registers; every memory-side pin comes from a flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_cs_q      <= 1'b0;
      mem_rd_q      <= 1'b1;
      mem_wr_q      <= 1'b1;
      data_oe       <= 1'b0;
      mem_address_q <= '0;
      gnt_q         <= 2'b00;
      ack_q         <= 2'b00;
      rdata_q       <= '0;
      owner         <= 1'b0;
      last          <= 1'b1;
      lat_we        <= 1'b0;
      lat_wdata     <= '0;
    end else begin
      mem_cs_q <= cs_nxt;
      mem_rd_q <= rd_nxt;
      mem_wr_q <= wr_nxt;
      data_oe  <= oe_nxt;
      gnt_q    <= gnt_nxt;
      ack_q    <= ack_nxt;
      if (grant) begin
        owner         <= win_port;
        last          <= win_port;
        lat_we        <= sel_we;
        lat_wdata     <= sel_wdata;
        mem_address_q <= sel_addr;
      end
      // memory drives read data during ACCESS; capture on the edge ending it
      if ((state == S_ACCESS) && !lat_we) rdata_q <= mem_data;
    end
  end

  assign mem_data        = data_oe ? lat_wdata : {DATA_WIDTH{1'bz}};
  assign bus.mem_cs      = mem_cs_q;
  assign bus.mem_rd      = mem_rd_q;
  assign bus.mem_wr      = mem_wr_q;
  assign bus.mem_address = mem_address_q;
  assign bus.gnt         = gnt_q;
  assign bus.ack0        = ack_q[0];
  assign bus.ack1        = ack_q[1];
  assign bus.rdata       = rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: round-robin and fixed-priority instances.
// Latency: checks issue/access/done cycle by cycle after each grant.
// Backpressure: holds requests through contention to check back-to-back service.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_WIDTH(20), .DATA_WIDTH(8)) ifr ();
  mem_port_arbiter_if #(.ADDR_WIDTH(20), .DATA_WIDTH(8)) ifp ();

  // undriven bus floats high so a released bus reads as 0xFF
  tri1 [7:0] md_rr;
  tri1 [7:0] md_fp;

  mem_port_arbiter #(.ADDR_WIDTH(20), .DATA_WIDTH(8), .FIXED_PRIO(0)) dut_rr (
    .clk(clk), .rst(rst), .bus(ifr), .mem_data(md_rr));

  mem_port_arbiter #(.ADDR_WIDTH(20), .DATA_WIDTH(8), .FIXED_PRIO(1)) dut_fp (
    .clk(clk), .rst(rst), .bus(ifp), .mem_data(md_fp));

  // memory model behind the round-robin instance: drives in ACCESS of a read,
  // stores the bus at the end of ACCESS of a write
  logic [7:0] mem_rr [0:1023];
  logic       rd_pend = 1'b0;
  logic       wr_pend = 1'b0;
  logic [9:0] rd_idx = '0;
  logic [9:0] wr_idx = '0;
  logic       bd_en = 1'b0;
  logic [9:0] bd_idx = '0;
  logic [7:0] bd_val = '0;

  // memory module state and backdoor preload
  always @(posedge clk) begin
    rd_pend <= ifr.mem_cs && !ifr.mem_rd;
    wr_pend <= ifr.mem_cs && !ifr.mem_wr;
    if (ifr.mem_cs) begin
      rd_idx <= ifr.mem_address[9:0];
      wr_idx <= ifr.mem_address[9:0];
    end
    if (wr_pend) mem_rr[wr_idx] <= md_rr;
    if (bd_en)   mem_rr[bd_idx] <= bd_val;
  end

  assign md_rr = rd_pend ? mem_rr[rd_idx] : 8'bzzzzzzzz;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  initial begin
    ifr.req0 = 0; ifr.req1 = 0; ifr.we0 = 0; ifr.we1 = 0;
    ifr.addr0 = '0; ifr.addr1 = '0; ifr.wdata0 = '0; ifr.wdata1 = '0;
    ifp.req0 = 0; ifp.req1 = 0; ifp.we0 = 0; ifp.we1 = 0;
    ifp.addr0 = '0; ifp.addr1 = '0; ifp.wdata0 = '0; ifp.wdata1 = '0;

    // reset state
    tick(); tick();
    chk("rst_cs",    ifr.mem_cs, 1'b0);
    chk("rst_rd",    ifr.mem_rd, 1'b1);
    chk("rst_wr",    ifr.mem_wr, 1'b1);
    chk("rst_addr",  ifr.mem_address, 20'h0);
    chk("rst_ack",   {ifr.ack1, ifr.ack0}, 2'b00);
    chk("rst_rdata", ifr.rdata, 8'h00);
    chk("rst_gnt",   ifr.gnt, 2'b00);
    chk("rst_bus",   md_rr, 8'hFF);
    chk("rst_gnt_fp", ifp.gnt, 2'b00);

    bd_en = 1; bd_idx = 10'h010; bd_val = 8'hA5;
    tick();
    bd_en = 0;
    rst = 0;
    tick();

    // single read, port 0
    ifr.req0 = 1; ifr.we0 = 0; ifr.addr0 = 20'h00010;
    tick();
    chk("rd_iss_cs",   ifr.mem_cs, 1'b1);
    chk("rd_iss_rd",   ifr.mem_rd, 1'b0);
    chk("rd_iss_wr",   ifr.mem_wr, 1'b1);
    chk("rd_iss_gnt",  ifr.gnt, 2'b01);
    chk("rd_iss_addr", ifr.mem_address, 20'h00010);
    tick();
    chk("rd_acc_cs",  ifr.mem_cs, 1'b0);
    chk("rd_acc_rd",  ifr.mem_rd, 1'b1);
    chk("rd_acc_bus", md_rr, 8'hA5);
    chk("rd_acc_ack", ifr.ack0, 1'b0);
    tick();
    chk("rd_done_ack",   ifr.ack0, 1'b1);
    chk("rd_done_rdata", ifr.rdata, 8'hA5);
    chk("rd_done_gnt",   ifr.gnt, 2'b01);
    ifr.req0 = 0;
    tick();
    chk("rd_idle_ack",   ifr.ack0, 1'b0);
    chk("rd_idle_gnt",   ifr.gnt, 2'b00);
    chk("rd_idle_rdata", ifr.rdata, 8'hA5);

    // port 1 write then read back
    ifr.req1 = 1; ifr.we1 = 1; ifr.addr1 = 20'h00200; ifr.wdata1 = 8'h3C;
    tick();
    chk("wr_iss_wr",  ifr.mem_wr, 1'b0);
    chk("wr_iss_rd",  ifr.mem_rd, 1'b1);
    chk("wr_iss_gnt", ifr.gnt, 2'b10);
    chk("wr_iss_bus", md_rr, 8'h3C);
    tick();
    chk("wr_acc_wr",  ifr.mem_wr, 1'b1);
    chk("wr_acc_bus", md_rr, 8'h3C);
    tick();
    chk("wr_done_ack",   ifr.ack1, 1'b1);
    chk("wr_done_rdata", ifr.rdata, 8'hA5);
    chk("wr_done_bus",   md_rr, 8'hFF);
    ifr.req1 = 0;
    tick();
    ifr.req1 = 1; ifr.we1 = 0;
    tick();
    chk("rb_iss_rd",  ifr.mem_rd, 1'b0);
    chk("rb_iss_gnt", ifr.gnt, 2'b10);
    tick();
    chk("rb_acc_bus", md_rr, 8'h3C);
    tick();
    chk("rb_done_ack",   ifr.ack1, 1'b1);
    chk("rb_done_rdata", ifr.rdata, 8'h3C);
    ifr.req1 = 0;
    tick();

    // round-robin contention: last served is port 1, so port 0 wins first
    ifr.req0 = 1; ifr.we0 = 1; ifr.addr0 = 20'h00100; ifr.wdata0 = 8'h11;
    ifr.req1 = 1; ifr.we1 = 1; ifr.addr1 = 20'h00101; ifr.wdata1 = 8'h22;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("rr_gnt", ifr.gnt, (k % 2 == 0) ? 2'b01 : 2'b10);
      chk("rr_cs",  ifr.mem_cs, 1'b1);
      chk("rr_bus", md_rr, (k % 2 == 0) ? 8'h11 : 8'h22);
      tick();
      tick();
      chk("rr_ack", {ifr.ack1, ifr.ack0}, (k % 2 == 0) ? 2'b01 : 2'b10);
      if (k == 5) begin
        ifr.req0 = 0;
        ifr.req1 = 0;
      end
    end
    tick();
    chk("rr_idle_gnt", ifr.gnt, 2'b00);
    chk("rr_idle_cs",  ifr.mem_cs, 1'b0);

    // fixed priority: port 0 first, re-request waits for port 1's ack
    ifp.req0 = 1; ifp.we0 = 1; ifp.addr0 = 20'h00001; ifp.wdata0 = 8'h01;
    ifp.req1 = 1; ifp.we1 = 1; ifp.addr1 = 20'h00002; ifp.wdata1 = 8'h02;
    tick();
    chk("fp_gnt_a", ifp.gnt, 2'b01);
    tick(); tick();
    chk("fp_ack_a", {ifp.ack1, ifp.ack0}, 2'b01);
    tick();
    chk("fp_gnt_b", ifp.gnt, 2'b10);
    tick(); tick();
    chk("fp_ack_b", {ifp.ack1, ifp.ack0}, 2'b10);
    ifp.req1 = 0;
    tick();
    chk("fp_gnt_c", ifp.gnt, 2'b01);
    tick(); tick();
    chk("fp_ack_c", {ifp.ack1, ifp.ack0}, 2'b01);
    ifp.req0 = 0;
    tick();
    chk("fp_idle", ifp.gnt, 2'b00);
    // port 0 was served last; a tie still goes to port 0
    ifp.req0 = 1; ifp.req1 = 1;
    tick();
    chk("fp_tie_gnt", ifp.gnt, 2'b01);
    tick(); tick();
    ifp.req0 = 0;
    tick();
    chk("fp_tie_next", ifp.gnt, 2'b10);
    tick(); tick();
    ifp.req1 = 0;
    tick();

    // reset asserted during ACCESS of a write
    ifr.req0 = 1; ifr.we0 = 1; ifr.addr0 = 20'h00300; ifr.wdata0 = 8'h77;
    tick();
    tick();
    chk("mr_acc_bus", md_rr, 8'h77);
    #2;
    rst = 1;
    #1;
    chk("mr_bus",   md_rr, 8'hFF);
    chk("mr_wr",    ifr.mem_wr, 1'b1);
    chk("mr_rd",    ifr.mem_rd, 1'b1);
    chk("mr_cs",    ifr.mem_cs, 1'b0);
    chk("mr_gnt",   ifr.gnt, 2'b00);
    chk("mr_rdata", ifr.rdata, 8'h00);
    chk("mr_addr",  ifr.mem_address, 20'h0);
    ifr.we0 = 0; ifr.addr0 = 20'h00010;
    tick();
    chk("mr_no_ack", ifr.ack0, 1'b0);
    rst = 0;
    tick();
    chk("mr_new_gnt", ifr.gnt, 2'b01);
    chk("mr_new_rd",  ifr.mem_rd, 1'b0);
    tick(); tick();
    chk("mr_new_ack",   ifr.ack0, 1'b1);
    chk("mr_new_rdata", ifr.rdata, 8'hA5);
    ifr.req0 = 0;
    tick();

    // bus turnaround: port 1 write then port 0 read back-to-back
    ifr.req1 = 1; ifr.we1 = 1; ifr.addr1 = 20'h00040; ifr.wdata1 = 8'h5A;
    ifr.req0 = 1; ifr.we0 = 0; ifr.addr0 = 20'h00200;
    tick();
    chk("ta_w_gnt", ifr.gnt, 2'b10);
    chk("ta_w_iss", md_rr, 8'h5A);
    tick();
    chk("ta_w_acc", md_rr, 8'h5A);
    tick();
    chk("ta_w_ack",  ifr.ack1, 1'b1);
    chk("ta_w_done", md_rr, 8'hFF);
    ifr.req1 = 0;
    tick();
    chk("ta_r_gnt", ifr.gnt, 2'b01);
    chk("ta_r_iss", md_rr, 8'hFF);
    tick();
    chk("ta_r_acc", md_rr, 8'h3C);
    tick();
    chk("ta_r_ack",   ifr.ack0, 1'b1);
    chk("ta_r_rdata", ifr.rdata, 8'h3C);
    chk("ta_r_done",  md_rr, 8'hFF);
    ifr.req0 = 0;
    tick();
    ifr.req0 = 1; ifr.addr0 = 20'h00040;
    tick(); tick(); tick();
    chk("ta_rb_ack",   ifr.ack0, 1'b1);
    chk("ta_rb_rdata", ifr.rdata, 8'h5A);
    ifr.req0 = 0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
